count_bcd_display: RTL and testbench

Display back-end for the 8-bit counter. It samples the counter's 8-bit output value on a strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed three-digit 7-segment display with leading-zero blanking. It sits directly downstream of the counter and feeds the `uo_out` pad logic.

---
 rtl/count_bcd_display.sv | 148 ++++++++++++++
 tb/tb_count_bcd_display.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/count_bcd_display.sv
// Samples an 8-bit value, converts it to three BCD digits with a sequential
// double-dabble engine, and scans a multiplexed 3-digit 7-segment display.
module count_bcd_display #(
    parameter int REFRESH_DIV    = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    input  logic        sample_en,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  digit_sel
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, CONV} state_t;
    typedef enum logic [1:0] {DIG_ONES, DIG_TENS, DIG_HUND} dig_t;

    state_t      r_state;
    logic [7:0]  r_bin;
    logic [11:0] r_scr;
    logic [2:0]  r_iter;
    logic [11:0] w_adj;
    logic [19:0] w_shift;

    logic [PW-1:0] r_pre;
    dig_t          r_dig;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [2:0]    w_sel;
    logic [6:0]    w_raw;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Add-3 correction on every scratch digit, then one combined left shift.
    always_comb begin
        w_adj = r_scr;
        for (int unsigned d = 0; d < 3; d++) begin
            if (r_scr[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
        end
        w_shift = {w_adj, r_bin} << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_scr   <= '0;
            r_iter  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_en) begin
                        r_bin   <= value;
                        r_scr   <= '0;
                        r_iter  <= '0;
                        busy    <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_scr  <= w_shift[19:8];
                    r_bin  <= w_shift[7:0];
                    r_iter <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        bcd     <= w_shift[19:8];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_dig <= DIG_ONES;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            case (r_dig)
                DIG_ONES: r_dig <= DIG_TENS;
                DIG_TENS: r_dig <= DIG_HUND;
                default:  r_dig <= DIG_ONES;
            endcase
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Blanked slots keep their digit_sel so the scan timing stays uniform.
    always_comb begin
        w_digit = bcd[3:0];
        w_sel   = 3'b001;
        w_blank = 1'b0;
        case (r_dig)
            DIG_TENS: begin
                w_digit = bcd[7:4];
                w_sel   = 3'b010;
                w_blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            DIG_HUND: begin
                w_digit = bcd[11:8];
                w_sel   = 3'b100;
                w_blank = (bcd[11:8] == 4'd0);
            end
            default: ;
        endcase
        w_raw = w_blank ? 7'h00 : seg_decode(w_digit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg       <= SEG_ACTIVE_LOW ? '1 : '0;
            digit_sel <= '0;
        end else begin
            seg       <= SEG_ACTIVE_LOW ? ~w_raw : w_raw;
            digit_sel <= w_sel;
        end
    end

endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: vector table of values with expected BCD and
// per-slot segment codes, scoreboarded results, plus reset and ignore cases.
module tb_count_bcd_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  value = '0;
    logic        sample_en = 1'b0;
    logic        busy0, done0, busy1, done1;
    logic [11:0] bcd0, bcd1;
    logic [6:0]  seg0, seg1;
    logic [2:0]  ds0, ds1;

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    int n_conv = 0;
    logic [11:0] sb_q[$];

    always #5 clk = ~clk;

    count_bcd_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u0 (
        .clk(clk), .reset(reset), .value(value), .sample_en(sample_en),
        .busy(busy0), .done(done0), .bcd(bcd0), .seg(seg0), .digit_sel(ds0)
    );

    count_bcd_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .reset(reset), .value(value), .sample_en(sample_en),
        .busy(busy1), .done(done1), .bcd(bcd1), .seg(seg1), .digit_sel(ds1)
    );

    typedef struct {
        logic [7:0]  v;
        logic [11:0] bcd;
        logic [6:0]  s_ones;
        logic [6:0]  s_tens;
        logic [6:0]  s_hund;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Scoreboard pop on every committed result.
    always @(negedge clk) begin
        if (!reset && done0) begin
            done_count++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 12'h001, 12'h000);
            end else begin
                chk("sb_bcd", bcd0, sb_q.pop_front());
            end
        end
    end

    task automatic conv(input logic [7:0] v, input logic [11:0] exp, input bit pester);
        int n;
        @(negedge clk);
        value = v;
        sample_en = 1'b1;
        sb_q.push_back(exp);
        n_conv++;
        @(negedge clk);
        n = 0;
        while (busy0 === 1'b1 && n < 20) begin
            n++;
            if (pester) begin
                sample_en = 1'b1;
                value = 8'd200;
            end else begin
                sample_en = 1'b0;
            end
            @(negedge clk);
        end
        sample_en = 1'b0;
        value = v;
        chk("busy_cycles", 12'(n), 12'd8);
        chk("done_high", {11'd0, done0}, 12'd1);
        @(negedge clk);
        chk("done_single", {11'd0, done0}, 12'd0);
        chk("busy_idle", {11'd0, busy0}, 12'd0);
    endtask

    task automatic check_scan(input bit sel, input logic [6:0] e1, input logic [6:0] e10,
                              input logic [6:0] e100);
        logic [2:0] prev, cur, eds;
        logic [6:0] cseg, eseg;
        int n;
        prev = sel ? ds1 : ds0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            cur = sel ? ds1 : ds0;
            if (cur == 3'b001 && prev != 3'b001) break;
            prev = cur;
        end while (n < 40);
        chk("scan_sync", {9'd0, cur}, 12'h001);
        for (int k = 0; k < 12; k++) begin
            eds  = (k < 4) ? 3'b001 : (k < 8) ? 3'b010 : 3'b100;
            eseg = (k < 4) ? e1 : (k < 8) ? e10 : e100;
            cur  = sel ? ds1 : ds0;
            cseg = sel ? seg1 : seg0;
            chk("scan_digit_sel", {9'd0, cur}, {9'd0, eds});
            chk("scan_seg", {5'd0, cseg}, {5'd0, eseg});
            @(negedge clk);
        end
    endtask

    initial begin
        int dc;
        vecs[0] = '{8'd255, 12'h255, 7'h6D, 7'h6D, 7'h5B};
        vecs[1] = '{8'd0,   12'h000, 7'h3F, 7'h00, 7'h00};
        vecs[2] = '{8'd105, 12'h105, 7'h6D, 7'h3F, 7'h06};
        vecs[3] = '{8'd99,  12'h099, 7'h6F, 7'h6F, 7'h00};
        vecs[4] = '{8'd10,  12'h010, 7'h3F, 7'h06, 7'h00};
        vecs[5] = '{8'd200, 12'h200, 7'h3F, 7'h3F, 7'h5B};
        vecs[6] = '{8'd8,   12'h008, 7'h7F, 7'h00, 7'h00};

        #2 reset = 1'b1;
        #1;
        chk("rst_busy", {11'd0, busy0}, 12'd0);
        chk("rst_done", {11'd0, done0}, 12'd0);
        chk("rst_bcd", bcd0, 12'h000);
        chk("rst_digit_sel", {9'd0, ds0}, 12'h000);
        chk("rst_seg", {5'd0, seg0}, 12'h000);
        chk("rst_seg_al", {5'd0, seg1}, 12'h07F);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("first_digit_sel", {9'd0, ds0}, 12'h001);
        chk("first_seg", {5'd0, seg0}, 12'h03F);
        chk("first_seg_al", {5'd0, seg1}, 12'h040);

        foreach (vecs[i]) begin
            conv(vecs[i].v, vecs[i].bcd, 1'b0);
            chk("vec_bcd", bcd0, vecs[i].bcd);
            check_scan(1'b0, vecs[i].s_ones, vecs[i].s_tens, vecs[i].s_hund);
        end

        // Requests while busy are dropped and not queued.
        conv(8'd7, 12'h007, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_queued_capture", {11'd0, busy0}, 12'd0);
        end
        chk("ignore_bcd", bcd0, 12'h007);
        check_scan(1'b0, 7'h07, 7'h00, 7'h00);

        // Reset in the middle of a conversion.
        @(negedge clk);
        value = 8'd99;
        sample_en = 1'b1;
        @(posedge clk);
        #1 sample_en = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        dc = done_count;
        chk("midrst_busy", {11'd0, busy0}, 12'd0);
        chk("midrst_done", {11'd0, done0}, 12'd0);
        chk("midrst_bcd", bcd0, 12'h000);
        chk("midrst_digit_sel", {9'd0, ds0}, 12'h000);
        chk("midrst_seg", {5'd0, seg0}, 12'h000);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", 12'(done_count - dc), 12'd0);
        chk("midrst_bcd_hold", bcd0, 12'h000);
        conv(8'd99, 12'h099, 1'b0);
        chk("after_rst_bcd", bcd0, 12'h099);

        // Active-low segment polarity.
        conv(8'd8, 12'h008, 1'b0);
        chk("al_bcd", bcd1, 12'h008);
        check_scan(1'b1, 7'h00, 7'h7F, 7'h7F);

        repeat (3) @(negedge clk);
        chk("sb_empty", 12'(sb_q.size()), 12'd0);
        chk("done_total", 12'(done_count), 12'(n_conv));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
